// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-indexed data memory.
// Converts byte-addressed byte/half/word loads and stores into 32-bit word
// accesses. Sub-word stores run as read-modify-write. One request in flight.
// Optional build macro: MISALIGN_TRAP_EN (misaligned half/word accesses are
// reported as errors instead of being aligned down).
module load_store_unit #(
   parameter int MEM_DEPTH = 55,
   parameter int IDX_BITS  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_endereco,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nxt;

   // Request fields held for the whole transaction
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic        unsigned_q;
   logic        err_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        hi_nz;
   logic [31:0] idx_ext;
   logic        oor;
   logic        misalign;
   logic        req_err;

   logic [31:0] byte_sh, half_sh, ld_data;
   logic [31:0] byte_mask, half_mask, merged;

   assign accept = req_valid && (state == IDLE);

   // Range check split at the memory decode width: any index bit above
   // IDX_BITS is out of range outright, the rest is compared to the depth.
   assign hi_nz   = |req_addr[31:IDX_BITS+2];
   assign idx_ext = {{(32-IDX_BITS){1'b0}}, req_addr[IDX_BITS+1:2]};
   assign oor     = hi_nz || (idx_ext >= 32'(MEM_DEPTH));

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_err = oor || misalign;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Request latch, word index and read-data capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q       <= '0;
         size_q       <= '0;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         err_q        <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         mem_endereco <= '0;
      end else begin
         if (accept) begin
            lane_q       <= req_addr[1:0];
            size_q       <= req_size;
            write_q      <= req_write;
            unsigned_q   <= req_unsigned;
            err_q        <= req_err;
            wdata_q      <= req_wdata;
            mem_endereco <= {2'b00, req_addr[31:2]};
         end
         if (state == RD) rdata_q <= mem_read_data;
      end
   end

   // Load extraction: move the lane to bit 0, then sign/zero-extend
   always_comb begin
      byte_sh = rdata_q >> {lane_q, 3'b000};
      half_sh = rdata_q >> {lane_q[1], 4'b0000};
      case (size_q)
         2'b00:   ld_data = {{24{byte_sh[7] & ~unsigned_q}}, byte_sh[7:0]};
         2'b01:   ld_data = {{16{half_sh[15] & ~unsigned_q}}, half_sh[15:0]};
         default: ld_data = rdata_q;
      endcase
   end

   // Store merge: replicate the store data across lanes, keep untouched lanes
   always_comb begin
      byte_mask = 32'h0000_00FF << {lane_q, 3'b000};
      half_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      case (size_q)
         2'b00:   merged = (rdata_q & ~byte_mask) | ({4{wdata_q[7:0]}} & byte_mask);
         2'b01:   merged = (rdata_q & ~half_mask) | ({2{wdata_q[15:0]}} & half_mask);
         default: merged = wdata_q;
      endcase
   end

   // Next state and per-state outputs; req_ready is held low while in reset
   always_comb begin
      state_nxt      = state;
      req_ready      = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = rst_n;
            if (accept) begin
               if (req_err)                       state_nxt = RESP;
               else if (req_write && req_size[1]) state_nxt = WR;
               else                               state_nxt = RD;
            end
         end
         RD: begin
            mem_read  = 1'b1;
            state_nxt = write_q ? WR : RESP;
         end
         WR: begin
            mem_write      = 1'b1;
            mem_write_data = merged;
            state_nxt      = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || write_q) ? 32'h0 : ld_data;
            state_nxt  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed tests for load_store_unit with a small
// word-indexed memory model. Outputs are sampled on the falling edge.
module tb_load_store_unit;

   localparam int MEM_DEPTH = 55;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_endereco;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_DEPTH(MEM_DEPTH), .IDX_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_endereco(mem_endereco),
      .mem_write_data(mem_write_data), .mem_write(mem_write),
      .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   // Memory model: commits on the rising edge, combinational read
   logic [31:0] mem [0:MEM_DEPTH-1];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (mem_write && (mem_endereco < 32'(MEM_DEPTH))) mem[mem_endereco[5:0]] <= mem_write_data;
      else if (pl_en) mem[pl_idx] <= pl_data;
   end

   assign mem_read_data = (mem_endereco < 32'(MEM_DEPTH)) ? mem[mem_endereco[5:0]] : 32'h0;

   int errors = 0;
   int checks = 0;

   // Per-transaction observations (cycle index k counted from the accept edge)
   int          rd_cnt, rd_k, wr_cnt, wr_k, rsp_cnt, rsp_k;
   logic [31:0] wr_data, wr_idx, rsp_data;
   logic        rsp_err, rdy_issue;

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(posedge clk); #1 pl_en = 1'b0;
      @(negedge clk);
   endtask

   // Issue one request at a falling edge and record activity for 6 cycles
   task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
      rd_cnt = 0; rd_k = 0; wr_cnt = 0; wr_k = 0; rsp_cnt = 0; rsp_k = 0;
      wr_data = '0; wr_idx = '0; rsp_data = '0; rsp_err = 1'b0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      rdy_issue = req_ready;
      @(posedge clk); #1 req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (mem_read) begin rd_cnt++; if (rd_k == 0) rd_k = k; end
         if (mem_write) begin
            wr_cnt++;
            if (wr_k == 0) begin wr_k = k; wr_data = mem_write_data; wr_idx = mem_endereco; end
         end
         if (resp_valid) begin
            rsp_cnt++;
            if (rsp_k == 0) begin rsp_k = k; rsp_data = resp_rdata; rsp_err = resp_err; end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      checks++; if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin errors++; $display("FAIL rst_ctl: got %b want 0000", {resp_valid, resp_err, mem_read, mem_write}); end
      checks++; if ({mem_endereco, mem_write_data, resp_rdata} !== 96'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {mem_endereco, mem_write_data, resp_rdata}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_load;
      preload(6'd3, 32'h8899AABB);
      run_req(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0);
      checks++; if (rdy_issue !== 1'b1) begin errors++; $display("FAIL lb_ready: got %b want 1", rdy_issue); end
      checks++; if (rsp_data !== 32'hFFFFFF99) begin errors++; $display("FAIL lb_data: got %h want ffffff99", rsp_data); end
      checks++; if (rsp_k !== 2 || rsp_cnt !== 1) begin errors++; $display("FAIL lb_resp_cycle: got %0d/%0d want 2/1", rsp_k, rsp_cnt); end
      checks++; if (rd_k !== 1 || rd_cnt !== 1 || wr_cnt !== 0) begin errors++; $display("FAIL lb_mem: rd %0d@%0d wr %0d want 1@1 wr 0", rd_cnt, rd_k, wr_cnt); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL lb_err: got %b want 0", rsp_err); end
      run_req(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0);
      checks++; if (rsp_data !== 32'h00000099) begin errors++; $display("FAIL lbu_data: got %h want 00000099", rsp_data); end
      run_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0);
      checks++; if (rsp_data !== 32'h00008899) begin errors++; $display("FAIL lhu_data: got %h want 00008899", rsp_data); end
      run_req(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_lo_data: got %h want ffffaabb", rsp_data); end
      run_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'hFFFFFFBB) begin errors++; $display("FAIL lb_lane0: got %h want ffffffbb", rsp_data); end
      run_req(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0);
      checks++; if (rsp_data !== 32'h00000088) begin errors++; $display("FAIL lbu_lane3: got %h want 00000088", rsp_data); end
      run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'h8899AABB) begin errors++; $display("FAIL lw_data: got %h want 8899aabb", rsp_data); end
   endtask

   task automatic test_store_sub;
      run_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h12345677);
      checks++; if (rd_k !== 1 || rd_cnt !== 1) begin errors++; $display("FAIL sb_read: %0d@%0d want 1@1", rd_cnt, rd_k); end
      checks++; if (wr_k !== 2 || wr_cnt !== 1) begin errors++; $display("FAIL sb_write_cycle: %0d@%0d want 1@2", wr_cnt, wr_k); end
      checks++; if (wr_data !== 32'h889977BB) begin errors++; $display("FAIL sb_merge: got %h want 889977bb", wr_data); end
      checks++; if (wr_idx !== 32'd3) begin errors++; $display("FAIL sb_index: got %0d want 3", wr_idx); end
      checks++; if (rsp_k !== 3 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL sb_resp: k %0d data %h err %b want 3 0 0", rsp_k, rsp_data, rsp_err); end
      run_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hCAFE1234);
      checks++; if (wr_data !== 32'h123477BB) begin errors++; $display("FAIL sh_merge: got %h want 123477bb", wr_data); end
      run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'h123477BB) begin errors++; $display("FAIL sh_readback: got %h want 123477bb", rsp_data); end
      // restore word 3 through a word store
      run_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h8899AABB);
      run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'h8899AABB) begin errors++; $display("FAIL sw_restore: got %h want 8899aabb", rsp_data); end
   endtask

   task automatic test_store_word;
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL sw_no_read: got %0d reads want 0", rd_cnt); end
      checks++; if (wr_k !== 1 || wr_cnt !== 1) begin errors++; $display("FAIL sw_write_cycle: %0d@%0d want 1@1", wr_cnt, wr_k); end
      checks++; if (wr_idx !== 32'd4 || wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write: idx %0d data %h want 4 deadbeef", wr_idx, wr_data); end
      checks++; if (rsp_k !== 2 || rsp_data !== 32'h0) begin errors++; $display("FAIL sw_resp: k %0d data %h want 2 0", rsp_k, rsp_data); end
      run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D);
      checks++; if (wr_k !== 1 || wr_data !== 32'h0BADF00D) begin errors++; $display("FAIL size3_word: k %0d data %h want 1 0badf00d", wr_k, wr_data); end
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++; if (rsp_data !== 32'h0BADF00D) begin errors++; $display("FAIL sw_readback: got %h want 0badf00d", rsp_data); end
   endtask

   task automatic test_out_of_range;
      run_req(1'b0, 2'b01, 1'b0, 32'hDC, 32'h0);
      checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin errors++; $display("FAIL oor_mem: rd %0d wr %0d want 0 0", rd_cnt, wr_cnt); end
      checks++; if (rsp_k !== 1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL oor_resp: k %0d err %b data %h want 1 1 0", rsp_k, rsp_err, rsp_data); end
      run_req(1'b1, 2'b10, 1'b0, 32'hDC, 32'h11111111);
      checks++; if (wr_cnt !== 0 || rsp_err !== 1'b1 || rsp_k !== 1) begin errors++; $display("FAIL oor_store: wr %0d err %b k %0d want 0 1 1", wr_cnt, rsp_err, rsp_k); end
      run_req(1'b0, 2'b10, 1'b0, 32'h40C, 32'h0);
      checks++; if (rd_cnt !== 0 || rsp_err !== 1'b1) begin errors++; $display("FAIL oor_high_idx: rd %0d err %b want 0 1", rd_cnt, rsp_err); end
      preload(6'd54, 32'h01234567);
      run_req(1'b0, 2'b10, 1'b0, 32'hD8, 32'h0);
      checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h01234567 || rsp_k !== 2) begin errors++; $display("FAIL last_word: err %b data %h k %0d want 0 01234567 2", rsp_err, rsp_data, rsp_k); end
   endtask

   task automatic test_misalign;
      run_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
`ifdef MISALIGN_TRAP_EN
      checks++; if (rsp_err !== 1'b1 || rsp_k !== 1 || rd_cnt !== 0 || rsp_data !== 32'h0) begin errors++; $display("FAIL lw_misalign: err %b k %0d rd %0d data %h want 1 1 0 0", rsp_err, rsp_k, rd_cnt, rsp_data); end
      run_req(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0);
      checks++; if (rsp_err !== 1'b1 || rd_cnt !== 0) begin errors++; $display("FAIL lh_misalign: err %b rd %0d want 1 0", rsp_err, rd_cnt); end
`else
      checks++; if (rsp_err !== 1'b0 || rsp_k !== 2 || rsp_data !== 32'h8899AABB) begin errors++; $display("FAIL lw_unaligned: err %b k %0d data %h want 0 2 8899aabb", rsp_err, rsp_k, rsp_data); end
      run_req(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0);
      checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'hFFFF8899) begin errors++; $display("FAIL lh_unaligned: err %b data %h want 0 ffff8899", rsp_err, rsp_data); end
`endif
   endtask

   task automatic test_reset_mid;
      int wr_seen, rsp_seen;
      wr_seen = 0; rsp_seen = 0;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h0C; req_wdata = 32'h00005555;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_rd: got %b want 1", mem_read); end
      rst_n = 1'b0;
      @(negedge clk);
      if (mem_write) wr_seen++;
      if (resp_valid) rsp_seen++;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_low: got %b want 0", req_ready); end
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b want 1", req_ready); end
         end
         if (mem_write) wr_seen++;
         if (resp_valid) rsp_seen++;
      end
      checks++; if (wr_seen !== 0 || rsp_seen !== 0) begin errors++; $display("FAIL rmid_abandon: wr %0d resp %0d want 0 0", wr_seen, rsp_seen); end
      run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
      checks++; if (rsp_data !== 32'h8899AABB) begin errors++; $display("FAIL rmid_word3: got %h want 8899aabb", rsp_data); end
   endtask

   task automatic test_back_to_back;
      logic [5:1] rdy;
      int         n_rsp;
      logic [5:1] rsp_at;
      rdy = '0; rsp_at = '0; n_rsp = 0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0C; req_wdata = 32'h0;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         rdy[k] = req_ready;
         if (resp_valid) begin n_rsp++; rsp_at[k] = 1'b1; end
      end
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rdy !== 5'b00100) begin errors++; $display("FAIL b2b_ready: got %b want 00100", rdy); end
      checks++; if (n_rsp !== 2 || rsp_at !== 5'b10010) begin errors++; $display("FAIL b2b_resp: n %0d at %b want 2 10010", n_rsp, rsp_at); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store_sub;
      test_store_word;
      test_out_of_range;
      test_misalign;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
